// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state types and baud divisor derivations
package uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam int         OS_RATE     = 16;
    localparam logic [3:0] OS_MID_CNT  = 4'd7;
    localparam logic [3:0] OS_LAST_CNT = 4'd15;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic int os_div(input int clk_freq, input int baud);
        return (clk_freq + (baud * OS_RATE) / 2) / (baud * OS_RATE);
    endfunction

endpackage

// File: rtl/uart_baud_rate_gen.sv
// rtl/uart_baud_rate_gen.sv - tx bit-enable and free-running 16x rx tick
module baud_rate_gen #(
    parameter int CLKS_PER_BIT = 434,
    parameter int OS_DIV       = 27
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tx_restart,
    output logic o_tx_bit_en,
    output logic o_rx_tick
);
    localparam int TX_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int RX_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(CLKS_PER_BIT - 1);
    localparam logic [RX_W-1:0] RX_LAST = RX_W'(OS_DIV - 1);

    logic [TX_W-1:0] r_tx_cnt;
    logic [RX_W-1:0] r_rx_cnt;

    assign o_tx_bit_en = (r_tx_cnt == TX_LAST);
    assign o_rx_tick   = (r_rx_cnt == RX_LAST);

    // Restart holds the bit counter at zero so a frame's start bit is a full period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (i_tx_restart || o_tx_bit_en) r_tx_cnt <= '0;
            else                             r_tx_cnt <= r_tx_cnt + 1'b1;
            if (o_rx_tick) r_rx_cnt <= '0;
            else           r_rx_cnt <= r_rx_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - 8N1 UART transmitter and 16x-oversampled receiver
module uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int OS_DIV       = os_div(CLK_FREQ, BAUD);

    tx_state_t  r_tx_state, w_tx_state_nxt;
    logic [7:0] r_tx_data, w_tx_data_nxt;
    logic [2:0] r_tx_idx, w_tx_idx_nxt;
    logic       r_tx, w_tx_nxt, r_tx_busy, w_tx_busy_nxt;
    logic       w_tx_bit_en, w_rx_tick, w_tx_restart;

    rx_state_t  r_rx_state, w_rx_state_nxt;
    logic [1:0] r_rx_sync;
    logic       r_rx_prev, w_rx_s, w_rx_fall;
    logic [3:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0] r_rx_idx, w_rx_idx_nxt;
    logic [7:0] r_rx_shift, w_rx_shift_nxt, r_dout, w_dout_nxt;
    logic       r_rdy, w_rdy_nxt, w_rx_done;

    assign w_tx_restart = (r_tx_state == TX_IDLE);

    baud_rate_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .OS_DIV       (OS_DIV)
    ) u_baud_rate_gen (
        .i_clk        (clk_50m),
        .i_rst_n      (rst_n),
        .i_tx_restart (w_tx_restart),
        .o_tx_bit_en  (w_tx_bit_en),
        .o_rx_tick    (w_rx_tick)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_data  <= '0;
            r_tx_idx   <= '0;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_busy  <= w_tx_busy_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_data_nxt  = r_tx_data;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_nxt       = r_tx;
        w_tx_busy_nxt  = r_tx_busy;
        case (r_tx_state)
            TX_IDLE: if (wr_en) begin
                w_tx_state_nxt = TX_START;
                w_tx_data_nxt  = din;
                w_tx_idx_nxt   = 3'd0;
                w_tx_nxt       = 1'b0;
                w_tx_busy_nxt  = 1'b1;
            end
            TX_START: if (w_tx_bit_en) begin
                w_tx_state_nxt = TX_DATA;
                w_tx_nxt       = r_tx_data[0];
            end
            TX_DATA: if (w_tx_bit_en) begin
                if (r_tx_idx == 3'd7) begin
                    w_tx_state_nxt = TX_STOP;
                    w_tx_nxt       = 1'b1;
                end else begin
                    w_tx_idx_nxt = r_tx_idx + 3'd1;
                    w_tx_nxt     = r_tx_data[r_tx_idx + 3'd1];
                end
            end
            TX_STOP: if (w_tx_bit_en) begin
                w_tx_state_nxt = TX_IDLE;
                w_tx_busy_nxt  = 1'b0;
                w_tx_nxt       = 1'b1;
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    assign w_rx_s    = r_rx_sync[1];
    // Edge-qualified so a line left low by a framing error does not re-arm the receiver.
    assign w_rx_fall = r_rx_prev & ~w_rx_s;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_dout     <= '0;
            r_rdy      <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], rx};
            r_rx_prev  <= w_rx_s;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_dout     <= w_dout_nxt;
            r_rdy      <= w_rdy_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (w_rx_fall) begin
                w_rx_state_nxt = RX_START;
                w_rx_cnt_nxt   = 4'd0;
            end
            RX_START: if (w_rx_tick) begin
                if (r_rx_cnt == OS_MID_CNT) begin
                    w_rx_cnt_nxt   = 4'd0;
                    w_rx_idx_nxt   = 3'd0;
                    w_rx_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 4'd1;
                end
            end
            RX_DATA: if (w_rx_tick) begin
                if (r_rx_cnt == OS_LAST_CNT) begin
                    w_rx_cnt_nxt   = 4'd0;
                    w_rx_shift_nxt = {w_rx_s, r_rx_shift[7:1]};
                    if (r_rx_idx == 3'd7) w_rx_state_nxt = RX_STOP;
                    else                  w_rx_idx_nxt   = r_rx_idx + 3'd1;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 4'd1;
                end
            end
            RX_STOP: if (w_rx_tick) begin
                if (r_rx_cnt == OS_LAST_CNT) begin
                    w_rx_cnt_nxt   = 4'd0;
                    w_rx_state_nxt = RX_IDLE;
                    w_rx_done      = w_rx_s;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt + 4'd1;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase

        w_dout_nxt = r_dout;
        w_rdy_nxt  = r_rdy;
        if (w_rx_done) begin
            w_dout_nxt = r_rx_shift;
            w_rdy_nxt  = 1'b1;
        end else if (rdy_clr) begin
            w_rdy_nxt = 1'b0;
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_tx_busy;
    assign rdy     = r_rdy;
    assign dout    = r_dout;

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - scoreboard bench for uart: loopback, driven rx frames, reset abort
module tb_uart;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int CPB      = 16;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] din     = 8'h00;
    logic       wr_en   = 1'b0;
    logic       tx, tx_busy, rx, rdy, rdy_clr;
    logic [7:0] dout;

    logic       loop_en  = 1'b1;
    logic       rx_drv   = 1'b1;
    logic       stim_clr = 1'b0;
    logic       mon_clr  = 1'b0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    assign rx      = loop_en ? tx : rx_drv;
    assign rdy_clr = stim_clr | mon_clr;

    uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .din     (din),
        .wr_en   (wr_en),
        .tx      (tx),
        .tx_busy (tx_busy),
        .rx      (rx),
        .rdy     (rdy),
        .rdy_clr (rdy_clr),
        .dout    (dout)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising rdy consumes one expected byte, then acknowledges it.
    initial begin : monitor
        logic       prev;
        logic [7:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge clk_50m);
            mon_clr = 1'b0;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (rdy && !prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got byte %0h expected none", dout);
                    end else begin
                        exp = exp_q.pop_front();
                        check("rx_byte", 32'(dout), 32'(exp));
                    end
                    mon_clr = 1'b1;
                end
                prev = rdy;
            end
        end
    end

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (tx_busy && n < 12 * CPB) begin
            @(negedge clk_50m);
            n++;
        end
        check("tx_idle_wait", 32'(tx_busy), 32'd0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20 * CPB) begin
            @(negedge clk_50m);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic send_tx(input logic [7:0] b, input logic expect_rx);
        wait_tx_idle();
        din   = b;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        if (expect_rx) begin
            exp_q.push_back(b);
            last_good = b;
        end
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit, output logic seen);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        seen = 1'b0;
        if (stop_bit) begin
            exp_q.push_back(b);
            last_good = b;
        end
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk_50m);
                if (rdy) begin
                    seen     = 1'b1;
                    stim_clr = 1'b0;
                end
            end
        end
        rx_drv   = 1'b1;
        stim_clr = 1'b0;
    endtask

    initial begin : stimulus
        logic [9:0] frame;
        int         wave_err;
        int         busy_cnt;
        int         tx_low;
        logic       seen;
        logic [7:0] b;
        logic       stop_bit;

        check("pkg_cpb_default", 32'(clks_per_bit(50000000, 115200)), 32'd434);
        check("pkg_osdiv_default", 32'(os_div(50000000, 115200)), 32'd27);

        repeat (3) @(negedge clk_50m);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);

        // 0x55 requested on the very first clock after reset release
        din   = 8'h55;
        wr_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        exp_q.push_back(8'h55);
        last_good = 8'h55;
        frame    = {1'b1, 8'h55, 1'b0};
        wave_err = 0;
        busy_cnt = 0;
        for (int t = 0; t < 12 * CPB; t++) begin
            if (!tx_busy) break;
            if (t < 10 * CPB && tx !== frame[t / CPB]) wave_err++;
            busy_cnt++;
            @(negedge clk_50m);
        end
        check("tx_wave_55", 32'(wave_err), 32'd0);
        check("tx_busy_len", 32'(busy_cnt), 32'(10 * CPB));
        wait_drain("drain_55");

        for (int i = 0; i < 256; i++) begin
            send_tx(8'(i), 1'b1);
            wait_drain("drain_seq");
        end

        // write while busy must be ignored
        send_tx(8'h3C, 1'b1);
        repeat (5 * CPB) @(negedge clk_50m);
        din   = 8'hA5;
        wr_en = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        din   = 8'h00;
        wait_drain("drain_3c");
        wait_tx_idle();
        tx_low = 0;
        repeat (12 * CPB) begin
            @(negedge clk_50m);
            if (!tx || tx_busy) tx_low++;
        end
        check("a5_not_sent", 32'(tx_low), 32'd0);

        // short low glitch on rx
        loop_en = 1'b0;
        rx_drv  = 1'b0;
        repeat (CPB / 4) @(negedge clk_50m);
        rx_drv = 1'b1;
        repeat (20 * CPB) @(negedge clk_50m);
        check("glitch_rdy", 32'(rdy), 32'd0);
        check("glitch_dout", 32'(dout), 32'(last_good));

        drive_rx_frame(8'hC3, 1'b0, seen);
        repeat (4 * CPB) @(negedge clk_50m);
        check("framing_rdy", 32'(rdy), 32'd0);
        check("framing_dout", 32'(dout), 32'(last_good));

        // rdy_clr held across completion
        repeat (2 * CPB) @(negedge clk_50m);
        stim_clr = 1'b1;
        drive_rx_frame(8'h96, 1'b1, seen);
        check("rdy_with_clr", 32'(seen), 32'd1);
        wait_drain("drain_96");

        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            repeat ($urandom_range(CPB, 3 * CPB)) @(negedge clk_50m);
            if ($urandom_range(0, 1) == 0) begin
                loop_en = 1'b1;
                send_tx(b, 1'b1);
            end else begin
                loop_en  = 1'b0;
                stop_bit = ($urandom_range(0, 3) != 0);
                drive_rx_frame(b, stop_bit, seen);
            end
            wait_drain("drain_rand");
            wait_tx_idle();
        end
        repeat (2 * CPB) @(negedge clk_50m);
        check("dout_last", 32'(dout), 32'(last_good));

        // reset mid-transmit aborts the frame; next byte still loops back
        loop_en = 1'b1;
        send_tx(8'hE7, 1'b0);
        repeat (4 * CPB + 3) @(negedge clk_50m);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_tx_busy", 32'(tx_busy), 32'd0);
        check("abort_rdy", 32'(rdy), 32'd0);
        check("abort_dout", 32'(dout), 32'd0);
        last_good = 8'h00;
        @(negedge clk_50m);
        din   = 8'h81;
        wr_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk_50m);
        wr_en = 1'b0;
        check("first_clk_accept", 32'(tx_busy), 32'd1);
        exp_q.push_back(8'h81);
        last_good = 8'h81;
        wait_drain("drain_81");
        repeat (4 * CPB) @(negedge clk_50m);
        check("final_dout", 32'(dout), 32'(last_good));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
- REQ-001: Parameters SHALL be, one per line:
  - CLK_FREQ, default 50000000, input clock frequency in Hz.
  - BAUD, default 115200, line bit rate.
- REQ-002: Ports SHALL be, one per line:
  - clk_50m  input  1  system clock, one clock only, all logic on its rising edge.
  - rst_n  input  1  reset, asynchronous, active-low.
  - din  input  8  byte to transmit.
  - wr_en  input  1  transmit request, sampled on each clock.
  - tx  output  1  serial output, idle high.
  - tx_busy  output  1  high while a frame is being transmitted.
  - rx  input  1  serial input, asynchronous to clk_50m.
  - rdy  output  1  received byte valid, sticky.
  - rdy_clr  input  1  clears rdy.
  - dout  output  8  last received byte.

Function
- REQ-003: Frame format SHALL be 8N1: one low start bit, 8 data bits LSB first, one high stop bit.
- REQ-004: Bit period SHALL be CLKS_PER_BIT = CLK_FREQ/BAUD, rounded to nearest (434 at default).
- REQ-005: The receiver SHALL oversample 16x using a tick every CLK_FREQ/(BAUD*16) clocks, rounded to nearest (27 at default).
- REQ-006: The transmitter SHALL be a 4-state FSM with states IDLE, START, DATA, STOP.
- REQ-007: In IDLE with wr_en=1, the transmitter SHALL latch din, assert tx_busy on the next clock, and drive the start bit from that same clock.
- REQ-008: In START, DATA and STOP, each bit SHALL last exactly CLKS_PER_BIT clocks; DATA SHALL shift out bits 0..7 of the latched byte.
- REQ-009: After the full stop-bit period, the transmitter SHALL return to IDLE and deassert tx_busy; a frame is 10*CLKS_PER_BIT clocks.
- REQ-010: wr_en while tx_busy=1 SHALL be ignored; the in-flight frame and latched byte SHALL be unaffected.
- REQ-011: wr_en asserted on the first IDLE clock SHALL be accepted.
- REQ-012: rx SHALL pass through a 2-flop synchronizer before any use.
- REQ-013: The receiver SHALL be an FSM with states IDLE, START, DATA, STOP.
- REQ-014: In IDLE, a synchronized low on rx SHALL enter START.
- REQ-015: START SHALL recheck rx at oversample tick 8; if rx is high the receiver SHALL return to IDLE (glitch rejection).
- REQ-016: Each data bit SHALL be sampled at tick 8 of its 16-tick period and shifted in LSB first.
- REQ-017: At tick 8 of the stop bit, if rx=1 the receiver SHALL load dout and set rdy=1.
- REQ-018: At tick 8 of the stop bit, if rx=0 (framing error) the receiver SHALL discard the byte and leave dout and rdy unchanged.
- REQ-019: From the stop-bit sample point, the receiver SHALL return to IDLE and be able to detect the next start edge.
- REQ-020: rdy SHALL stay high until rdy_clr=1 is sampled, then clear on the next clock.
- REQ-021: If rdy_clr=1 and a new byte completes on the same clock, rdy SHALL remain 1 and dout SHALL take the new byte.
- REQ-022: A new byte completing while rdy=1 SHALL overwrite dout; no overrun flag is provided.
- REQ-023: Transmitter and receiver SHALL operate independently and concurrently; a loopback of tx to rx SHALL work.
- REQ-024: All baud and tick counters SHALL wrap back to 0 after their terminal count, never exceeding it.

Reset
- REQ-025: rst_n low SHALL asynchronously force: tx=1, tx_busy=0, rdy=0, dout=8'h00, both FSMs to IDLE, all counters and shift registers to 0, synchronizer flops to 1.
- REQ-026: Reset asserted mid-frame SHALL abort the frame with no partial byte delivered.
- REQ-027: After rst_n rises, the first wr_en SHALL be accepted on the first clock.

Structure
- REQ-028: Package uart_pkg SHALL hold the CLKS_PER_BIT and oversample divisor derivation functions and the tx/rx state enums.
- REQ-029: A single sub-module baud_rate_gen SHALL generate the tx bit-enable and the 16x rx tick from clk_50m.
- REQ-030: The tx bit-enable from baud_rate_gen SHALL restart on frame start.
- REQ-031: Tx and rx FSMs SHALL reside in uart.

Verification
- REQ-032: Loopback tx to rx, send 0x00..0xFF sequentially, waiting for rdy each time -> each dout equals the sent byte; rdy_clr pulsed after each.
- REQ-033: Send 0x55 -> tx low for 434 clocks, then alternating 1,0,... bits, then high stop; tx_busy high for 4340 clocks.
- REQ-034: Pulse wr_en with din=0xA5 mid-frame of 0x3C -> only 0x3C received; 0xA5 never transmitted.
- REQ-035: Drive rx low for 100 clocks then high -> rdy stays 0 and dout is unchanged.
- REQ-036: Drive a frame with stop bit 0 -> rdy stays 0.
- REQ-037: Pulse rdy_clr on the same clock that a byte completes -> rdy stays 1.
- REQ-038: Assert rst_n low mid-transmit -> tx=1 and tx_busy=0 immediately; a subsequent 0x81 loops back correctly.
